stepper_multi_axis: RTL and testbench

STEPPER_MULTI_AXIS -- requirements
Module: stepper_multi_axis

---
 rtl/stepper_multi_axis.sv | 238 +++++++++++++++++++++++
 tb/tb_stepper_multi_axis.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_multi_axis.sv
// ---------------------------------------------------------------------------
// stepper_multi_axis
//
// Multi-channel step/direction pulse generator. A rising edge on start (in
// IDLE) latches a signed step count and a half-period per channel. Every
// channel then emits |count| step pulses, each speed cycles high and speed
// cycles low, in parallel with the others. When the last channel finishes, a
// one-cycle done pulse is produced.
//
// Optional feature: define STEPPER_ENDSTOP_EN to let the limit switches stop
// individual channels. A channel moving negative stops on endstop_min, and a
// channel moving positive stops on endstop_max. The stop also sets that
// channel's sticky endstop_hit bit. Without the macro the limit inputs are
// ignored and endstop_hit reads 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        level; rising edge in IDLE requests a move
//   abort        stops every channel while RUN
//   step_in      CHANNELS x CNT_W signed step counts, ch0 in LSBs
//   speed_in     CHANNELS x DIV_W half-period in clk cycles (0 acts as 1)
//   endstop_min  per-channel negative-side limit switch
//   endstop_max  per-channel positive-side limit switch
//   step         per-channel step pulse
//   dir          per-channel direction, 1 = negative
//   remaining    CHANNELS x CNT_W signed steps not yet issued
//   busy         high while RUN
//   done         one-cycle pulse when a move (or empty request) completes
//   endstop_hit  per-channel sticky limit-stop flag, cleared on accept
//
// FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a start rising edge
//   S_RUN    | at least one channel still pulsing
//   S_FINISH | one cycle: busy=0, done=1, then back to IDLE
// ---------------------------------------------------------------------------
module stepper_multi_axis #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int DIV_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHANNELS*CNT_W-1:0] step_in,
  input  logic [CHANNELS*DIV_W-1:0] speed_in,
  input  logic [CHANNELS-1:0]       endstop_min,
  input  logic [CHANNELS-1:0]       endstop_max,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS*CNT_W-1:0] remaining,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS-1:0]       endstop_hit
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAG_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MOST_NEG = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   start_prev_q, start_prev_d;
  logic   start_rise;
  logic   any_nz;

  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] step_q, step_d;
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [CHANNELS-1:0] hit_q, hit_d;

  logic [CHANNELS-1:0][CNT_W-1:0] mag_q, mag_d;
  logic [CHANNELS-1:0][DIV_W-1:0] spd_q, spd_d;
  logic [CHANNELS-1:0][DIV_W-1:0] tmr_q, tmr_d;

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_in;
  logic [CHANNELS-1:0][CNT_W-1:0] mag_in;
  logic [CHANNELS-1:0][DIV_W-1:0] spd_raw;
  logic [CHANNELS-1:0][DIV_W-1:0] spd_fix;
  logic [CHANNELS-1:0][CNT_W-1:0] rem_w;
  logic [CHANNELS-1:0]            es_stop;

  // Packed 2-D views of the flat buses; element 0 lands in the LSBs.
  assign cnt_in  = step_in;
  assign spd_raw = speed_in;
  assign any_nz  = |step_in;

  // Magnitude of each requested count. The most negative value has no
  // positive twin, so it saturates to the largest positive magnitude.
  always_comb begin
    mag_in  = '0;
    spd_fix = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cnt_in[i][CNT_W-1]) begin
        mag_in[i] = (cnt_in[i] == MOST_NEG) ? MAG_MAX : (~cnt_in[i] + CNT_ONE);
      end else begin
        mag_in[i] = cnt_in[i];
      end
      spd_fix[i] = (spd_raw[i] == '0) ? DIV_ONE : spd_raw[i];
    end
  end

`ifdef STEPPER_ENDSTOP_EN
  // Only the switch on the side the channel is travelling toward matters.
  always_comb begin
    es_stop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      es_stop[i] = dir_q[i] ? endstop_min[i] : endstop_max[i];
    end
  end
`else
  logic unused_endstop;
  assign unused_endstop = ^{endstop_min, endstop_max};
  assign es_stop        = '0;
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    active_d     = active_q;
    step_d       = step_q;
    dir_d        = dir_q;
    hit_d        = hit_q;
    mag_d        = mag_q;
    spd_d        = spd_q;
    tmr_d        = tmr_q;
    start_rise   = start & ~start_prev_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          if (any_nz) begin
            state_d = S_RUN;
            hit_d   = '0;
            for (int i = 0; i < CHANNELS; i++) begin
              active_d[i] = |cnt_in[i];
              dir_d[i]    = cnt_in[i][CNT_W-1];
              mag_d[i]    = mag_in[i];
              spd_d[i]    = spd_fix[i];
              // Timer at zero makes step rise on the next edge, giving
              // exactly one cycle of dir setup.
              tmr_d[i]    = '0;
              step_d[i]   = 1'b0;
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_RUN: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (active_q[i]) begin
            if (abort || es_stop[i]) begin
              // A pulse cut short while high still counts as issued.
              active_d[i] = 1'b0;
              if (step_q[i]) begin
                step_d[i] = 1'b0;
                mag_d[i]  = mag_q[i] - CNT_ONE;
              end
              if (es_stop[i]) begin
                hit_d[i] = 1'b1;
              end
            end else if (tmr_q[i] != '0) begin
              tmr_d[i] = tmr_q[i] - DIV_ONE;
            end else if (step_q[i]) begin
              step_d[i] = 1'b0;
              mag_d[i]  = mag_q[i] - CNT_ONE;
              tmr_d[i]  = spd_q[i] - DIV_ONE;
            end else if (mag_q[i] != '0) begin
              step_d[i] = 1'b1;
              tmr_d[i]  = spd_q[i] - DIV_ONE;
            end else begin
              // Trailing low half-period of the last pulse has elapsed.
              active_d[i] = 1'b0;
            end
          end
        end
        if (active_d == '0) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // start_prev resets high so a start held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      active_q     <= '0;
      step_q       <= '0;
      dir_q        <= '0;
      hit_q        <= '0;
      mag_q        <= '0;
      spd_q        <= '0;
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      active_q     <= active_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      hit_q        <= hit_d;
      mag_q        <= mag_d;
      spd_q        <= spd_d;
      tmr_q        <= tmr_d;
    end
  end

  always_comb begin
    rem_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rem_w[i] = dir_q[i] ? (~mag_q[i] + CNT_ONE) : mag_q[i];
    end
  end

  assign remaining   = rem_w;
  assign step        = step_q;
  assign dir         = dir_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FINISH);
  assign endstop_hit = hit_q;

endmodule

// File: tb/tb_stepper_multi_axis.sv
// Directed bench for stepper_multi_axis (CHANNELS=4, 32-bit counts/dividers).
// Cycle k is counted from the acceptance cycle A (k=0); outputs are sampled
// on the falling clock edge and inputs are changed there too.
module tb_stepper_multi_axis;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CH*CW-1:0]  step_in;
  logic [CH*DW-1:0]  speed_in;
  logic [CH-1:0]     endstop_min;
  logic [CH-1:0]     endstop_max;
  logic [CH-1:0]     step;
  logic [CH-1:0]     dir;
  logic [CH*CW-1:0]  remaining;
  logic              busy;
  logic              done;
  logic [CH-1:0]     endstop_hit;

  int checks = 0;
  int passed = 0;

  stepper_multi_axis #(.CHANNELS(CH), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .step_in(step_in), .speed_in(speed_in),
    .endstop_min(endstop_min), .endstop_max(endstop_max),
    .step(step), .dir(dir), .remaining(remaining),
    .busy(busy), .done(done), .endstop_hit(endstop_hit)
  );

  always #5 clk = ~clk;

  function automatic int rem(input int ch);
    logic signed [CW-1:0] v;
    v = remaining[ch*CW +: CW];
    return int'(v);
  endfunction

  task automatic set_ch(input int ch, input int cnt, input int spd);
    step_in[ch*CW +: CW]  = cnt;
    speed_in[ch*DW +: DW] = spd;
  endtask

  // Produces a start rising edge; returns at the negedge of acceptance cycle A.
  task automatic kick();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    step_in = '0; speed_in = '0; endstop_min = '0; endstop_max = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (step !== '0) $display("FAIL reset_step: got %b want 0", step); else passed++;
    checks++; if (dir !== '0) $display("FAIL reset_dir: got %b want 0", dir); else passed++;
    checks++; if (remaining !== '0) $display("FAIL reset_remaining: got %h want 0", remaining); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done); else passed++;
    checks++; if (endstop_hit !== '0) $display("FAIL reset_hit: got %b want 0", endstop_hit); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ch0 +3, half-period 2: pulses at k=1-2, 5-6, 9-10; done at k=13.
  task automatic test_basic();
    step_in = '0; speed_in = '0;
    set_ch(0, 3, 2);
    kick();
    checks++; if (busy !== 1'b1) $display("FAIL basic_accept_busy: got %b want 1", busy); else passed++;
    checks++; if (dir[0] !== 1'b0 || step[0] !== 1'b0) $display("FAIL basic_accept_dir_step: got %b/%b want 0/0", dir[0], step[0]); else passed++;
    checks++; if (rem(0) !== 3) $display("FAIL basic_accept_rem: got %0d want 3", rem(0)); else passed++;
    for (int k = 1; k <= 15; k++) begin
      int s = 2; int n = 3; int j; int nf; logic eh;
      @(negedge clk);
      j  = (k - 1) / (2 * s);
      eh = (j < n) && (((k - 1) % (2 * s)) < s);
      nf = (k >= 1 + s) ? ((k - 1 - s) / (2 * s) + 1) : 0;
      if (nf > n) nf = n;
      checks++; if (step[0] !== eh) $display("FAIL basic_step k=%0d: got %b want %b", k, step[0], eh); else passed++;
      checks++; if (rem(0) !== n - nf) $display("FAIL basic_rem k=%0d: got %0d want %0d", k, rem(0), n - nf); else passed++;
      checks++; if (done !== (k == 13)) $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == 13)); else passed++;
      checks++; if (busy !== (k < 13)) $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, (k < 13)); else passed++;
    end
    start = 1'b0;
  endtask

  // ch1 -5, half-period 1: step high on odd k, falls on even k; done at k=11.
  task automatic test_negative();
    int rises = 0;
    logic prev = 1'b0;
    step_in = '0; speed_in = '0;
    set_ch(1, -5, 1);
    kick();
    checks++; if (dir[1] !== 1'b1 || step[1] !== 1'b0) $display("FAIL neg_accept_dir_step: got %b/%b want 1/0", dir[1], step[1]); else passed++;
    checks++; if (rem(1) !== -5) $display("FAIL neg_accept_rem: got %0d want -5", rem(1)); else passed++;
    for (int k = 1; k <= 12; k++) begin
      int nf;
      @(negedge clk);
      nf = (k >= 2) ? k / 2 : 0;
      if (nf > 5) nf = 5;
      if (step[1] && !prev) rises++;
      prev = step[1];
      checks++; if (step[1] !== ((k % 2 == 1) && k <= 9)) $display("FAIL neg_step k=%0d: got %b", k, step[1]); else passed++;
      checks++; if (rem(1) !== -(5 - nf)) $display("FAIL neg_rem k=%0d: got %0d want %0d", k, rem(1), -(5 - nf)); else passed++;
      checks++; if (done !== (k == 11)) $display("FAIL neg_done k=%0d: got %b want %b", k, done, (k == 11)); else passed++;
    end
    checks++; if (rises !== 5) $display("FAIL neg_pulse_count: got %0d want 5", rises); else passed++;
    start = 1'b0;
  endtask

  task automatic test_zero();
    step_in = '0; speed_in = '0;
    kick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || step !== '0) $display("FAIL zero_after: got done=%b busy=%b step=%b want 0/0/0", done, busy, step); else passed++;
    start = 1'b0;
  endtask

  // ch3 +2 with speed 0 behaves as speed 1.
  task automatic test_speed0();
    step_in = '0; speed_in = '0;
    set_ch(3, 2, 0);
    kick();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (step[3] !== (k == 1 || k == 3)) $display("FAIL spd0_step k=%0d: got %b", k, step[3]); else passed++;
      checks++; if (done !== (k == 5)) $display("FAIL spd0_done k=%0d: got %b want %b", k, done, (k == 5)); else passed++;
    end
    start = 1'b0;
  endtask

  // ch0 +2/1 and ch1 -1/3 together; done follows the slower channel (k=7).
  // start is toggled during RUN and then held high: neither may retrigger.
  task automatic test_multi();
    step_in = '0; speed_in = '0;
    set_ch(0, 2, 1);
    set_ch(1, -1, 3);
    kick();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (step[0] !== (k == 1 || k == 3)) $display("FAIL multi_step0 k=%0d: got %b", k, step[0]); else passed++;
      checks++; if (step[1] !== (k >= 1 && k <= 3)) $display("FAIL multi_step1 k=%0d: got %b", k, step[1]); else passed++;
      checks++; if (done !== (k == 7)) $display("FAIL multi_done k=%0d: got %b want %b", k, done, (k == 7)); else passed++;
      checks++; if (busy !== (k < 7)) $display("FAIL multi_busy k=%0d: got %b want %b", k, busy, (k < 7)); else passed++;
      if (k == 1) start = 1'b0;
      if (k == 2) start = 1'b1;
    end
    start = 1'b0;
  endtask

`ifdef STEPPER_ENDSTOP_EN
  // ch2 -10/1: endstop_max (wrong side) ignored; endstop_min after 4 pulses stops it at -6.
  task automatic test_endstop();
    step_in = '0; speed_in = '0;
    set_ch(2, -10, 1);
    kick();
    endstop_max[2] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        checks++; if (step[2] !== (k % 2 == 1)) $display("FAIL es_step k=%0d: got %b", k, step[2]); else passed++;
        checks++; if (rem(2) !== -(10 - k / 2)) $display("FAIL es_rem k=%0d: got %0d want %0d", k, rem(2), -(10 - k / 2)); else passed++;
        checks++; if (endstop_hit[2] !== 1'b0) $display("FAIL es_hit_early k=%0d: got %b want 0", k, endstop_hit[2]); else passed++;
      end else begin
        checks++; if (step[2] !== 1'b0 || rem(2) !== -6) $display("FAIL es_stopped k=%0d: got step=%b rem=%0d want 0/-6", k, step[2], rem(2)); else passed++;
        checks++; if (endstop_hit[2] !== 1'b1) $display("FAIL es_hit k=%0d: got %b want 1", k, endstop_hit[2]); else passed++;
      end
      checks++; if (done !== (k == 9)) $display("FAIL es_done k=%0d: got %b want %b", k, done, (k == 9)); else passed++;
      if (k == 3) endstop_max[2] = 1'b0;
      if (k == 8) endstop_min[2] = 1'b1;
    end
    endstop_min = '0;
    start = 1'b0;
  endtask
`else
  // Limit switches have no effect and endstop_hit stays 0.
  task automatic test_endstop();
    step_in = '0; speed_in = '0;
    set_ch(2, -2, 1);
    endstop_min = '1; endstop_max = '1;
    kick();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (step[2] !== (k == 1 || k == 3)) $display("FAIL noes_step k=%0d: got %b", k, step[2]); else passed++;
      checks++; if (done !== (k == 5)) $display("FAIL noes_done k=%0d: got %b want %b", k, done, (k == 5)); else passed++;
      checks++; if (endstop_hit !== '0) $display("FAIL noes_hit k=%0d: got %b want 0", k, endstop_hit); else passed++;
    end
    endstop_min = '0; endstop_max = '0;
    start = 1'b0;
  endtask
`endif

  // ch0 +8/2: abort sampled while the second pulse is high -> remaining 6.
  task automatic test_abort();
    int dones = 0;
    step_in = '0; speed_in = '0;
    set_ch(0, 8, 2);
    kick();
    checks++; if (endstop_hit !== '0) $display("FAIL abort_hit_cleared: got %b want 0", endstop_hit); else passed++;
    for (int k = 1; k <= 9; k++) begin
      int exp_rem;
      @(negedge clk);
      if (done) dones++;
      exp_rem = (k >= 6) ? 6 : ((k >= 3) ? 7 : 8);
      checks++; if (step[0] !== (k <= 5 && ((k - 1) % 4) < 2)) $display("FAIL abort_step k=%0d: got %b", k, step[0]); else passed++;
      checks++; if (rem(0) !== exp_rem) $display("FAIL abort_rem k=%0d: got %0d want %0d", k, rem(0), exp_rem); else passed++;
      checks++; if (done !== (k == 6)) $display("FAIL abort_done k=%0d: got %b want %b", k, done, (k == 6)); else passed++;
      if (k == 5) abort = 1'b1;
      if (k == 6) abort = 1'b0;
    end
    checks++; if (dones !== 1) $display("FAIL abort_done_count: got %0d want 1", dones); else passed++;
    start = 1'b0;
  endtask

  // ch0 +1/2: abort coincides with the only falling edge -> one done at k=3.
  task automatic test_abort_final();
    int dones = 0;
    step_in = '0; speed_in = '0;
    set_ch(0, 1, 2);
    kick();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) dones++;
      checks++; if (step[0] !== (k <= 2)) $display("FAIL abfin_step k=%0d: got %b", k, step[0]); else passed++;
      checks++; if (rem(0) !== ((k <= 2) ? 1 : 0)) $display("FAIL abfin_rem k=%0d: got %0d", k, rem(0)); else passed++;
      checks++; if (done !== (k == 3)) $display("FAIL abfin_done k=%0d: got %b want %b", k, done, (k == 3)); else passed++;
      if (k == 2) abort = 1'b1;
      if (k == 3) abort = 1'b0;
    end
    checks++; if (dones !== 1) $display("FAIL abfin_done_count: got %0d want 1", dones); else passed++;
    start = 1'b0;
  endtask

  // Reset mid-move with start held high through the release.
  task automatic test_reset_mid();
    step_in = '0; speed_in = '0;
    set_ch(0, -8, 2);
    kick();
    @(negedge clk); @(negedge clk);
    checks++; if (step[0] !== 1'b1) $display("FAIL rmid_pre_step: got %b want 1", step[0]); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (step !== '0 || dir !== '0) $display("FAIL rmid_step_dir: got %b/%b want 0/0", step, dir); else passed++;
    checks++; if (remaining !== '0) $display("FAIL rmid_remaining: got %h want 0", remaining); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_busy_done: got %b%b want 00", busy, done); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || step !== '0 || done !== 1'b0) $display("FAIL rmid_hold k=%0d: got busy=%b step=%b done=%b want 0", k, busy, step, done); else passed++;
    end
    kick();
    checks++; if (busy !== 1'b1 || dir[0] !== 1'b1) $display("FAIL rmid_restart: got busy=%b dir0=%b want 1/1", busy, dir[0]); else passed++;
    start = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0 || rem(0) !== 0) $display("FAIL rmid_complete: got busy=%b rem=%0d want 0/0", busy, rem(0)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_speed0();
    test_multi();
    test_endstop();
    test_abort();
    test_abort_final();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
